register_file: RTL and testbench
================================

Name: register_file

Overview:
- 32-entry × 32-bit general-purpose register file for the pipelined CPU datapath.
- Two combinational read ports (A/B) and one synchronous write port.
- Register 0 is hard-wired to zero.
- All 32 register values are also exported on dedicated debug outputs (regOut0..regOut31) for co-simulation state comparison.

Parameters:
- WIDTH, 32, data width of each register and of BusA/BusB/BusW/regOutN.

Ports:
- Clk  input  1  system clock. One clock domain; all writes occur on its rising edge.
- Rst  input  1  reset, asynchronous, active-high. Clears every register to 0.
- BusW  input  WIDTH  write data.
- RW  input  5  write register address.
- RegWr  input  1  write enable, active-high.
- RA  input  5  read address, port A.
- RB  input  5  read address, port B.
- BusA  output  WIDTH  read data, port A.
- BusB  output  WIDTH  read data, port B.
- regOut0 .. regOut31  output  WIDTH each  current stored contents of registers 0..31 (32 separate ports).

Behaviour:
- Storage: 32 registers, each WIDTH bits.
- Reset:
  - Rst high: all registers become 0 immediately, with no clock edge needed.
  - Consequently BusA, BusB and every regOutN read 0 while Rst is high.
  - Rst dominates any write on the same edge.
- Write:
  - On the rising edge of Clk with Rst low, RegWr=1 and RW≠0: reg[RW] <= BusW.
  - RegWr=0: no state change.
  - RW=0: the write is discarded; register 0 stays 0 permanently.
- Read:
  - Purely combinational, zero latency.
  - BusA = reg[RA] and BusB = reg[RB], with the following exceptions:
    - RA=0 forces BusA=0; RB=0 forces BusB=0.
    - Write-through bypass: if RegWr=1, RW≠0 and RA==RW, then BusA=BusW. Same rule for RB/BusB.
  - The bypass means a value being written in a cycle is visible on the read ports in that same cycle (WB→ID in one cycle).
  - The bypass is not applied while Rst is high.
- Debug outputs:
  - regOutN = reg[N] combinationally, showing stored state only (no bypass).
  - regOut0 is constant 0.
  - A write becomes visible on regOutN right after the clock edge that commits it.
- Both read ports may address the same register, or the write register, simultaneously; each port resolves independently.
- No X propagation from uninitialised state: state is defined after the first reset. The bench shall assert Rst before any check.

Test Plan:
- Reset clear:
  - Preload reg5=0xDEADBEEF, then pulse Rst high mid-cycle (no clock edge).
  - Required: regOut5=0 and BusA (RA=5) =0 immediately; all regOut0..31 = 0.
- Basic write/read:
  - RegWr=1, RW=7, BusW=0x12345678, clock edge; then RegWr=0, RA=7, RB=7.
  - Required: BusA=BusB=0x12345678 and regOut7=0x12345678.
- Register-zero immunity:
  - RegWr=1, RW=0, BusW=0xFFFFFFFF, clock edge; RA=0.
  - Required: BusA=0 and regOut0=0.
- Write-through bypass:
  - reg3=0x11111111; set RegWr=1, RW=3, BusW=0x22222222, RA=3, RB=4 before the edge.
  - Required: BusA=0x22222222 pre-edge while regOut3 is still 0x11111111; regOut3=0x22222222 after the edge.
- Write-enable gating:
  - RegWr=0, RW=9, BusW=0xAAAA5555, clock edge.
  - Required: regOut9 is unchanged (0 after reset).
- Full sweep:
  - Write reg[i]=i×0x01010101 for i=1..31, then read all pairs (RA=i, RB=31−i).
  - Required: each BusA/BusB and each regOutN matches, and regOut0=0.

Source files
------------

// File: rtl/register_file.sv
// 32 x WIDTH register file: two combinational read ports with write-through bypass, one write port.
// Reads are zero-latency. Writes commit on the rising Clk edge. There is no flow control; a write is accepted every cycle.
module register_file #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] BusW,
  input  logic [4:0]       RW,
  input  logic             RegWr,
  input  logic [4:0]       RA,
  input  logic [4:0]       RB,
  output logic [WIDTH-1:0] BusA,
  output logic [WIDTH-1:0] BusB,
  output logic [WIDTH-1:0] regOut0,
  output logic [WIDTH-1:0] regOut1,
  output logic [WIDTH-1:0] regOut2,
  output logic [WIDTH-1:0] regOut3,
  output logic [WIDTH-1:0] regOut4,
  output logic [WIDTH-1:0] regOut5,
  output logic [WIDTH-1:0] regOut6,
  output logic [WIDTH-1:0] regOut7,
  output logic [WIDTH-1:0] regOut8,
  output logic [WIDTH-1:0] regOut9,
  output logic [WIDTH-1:0] regOut10,
  output logic [WIDTH-1:0] regOut11,
  output logic [WIDTH-1:0] regOut12,
  output logic [WIDTH-1:0] regOut13,
  output logic [WIDTH-1:0] regOut14,
  output logic [WIDTH-1:0] regOut15,
  output logic [WIDTH-1:0] regOut16,
  output logic [WIDTH-1:0] regOut17,
  output logic [WIDTH-1:0] regOut18,
  output logic [WIDTH-1:0] regOut19,
  output logic [WIDTH-1:0] regOut20,
  output logic [WIDTH-1:0] regOut21,
  output logic [WIDTH-1:0] regOut22,
  output logic [WIDTH-1:0] regOut23,
  output logic [WIDTH-1:0] regOut24,
  output logic [WIDTH-1:0] regOut25,
  output logic [WIDTH-1:0] regOut26,
  output logic [WIDTH-1:0] regOut27,
  output logic [WIDTH-1:0] regOut28,
  output logic [WIDTH-1:0] regOut29,
  output logic [WIDTH-1:0] regOut30,
  output logic [WIDTH-1:0] regOut31
);

  logic [WIDTH-1:0] regs [32];
  logic             wrActive;

  // Writes to register 0 are dropped here, so regs[0] never leaves its reset value.
  assign wrActive = RegWr && (RW != 5'd0);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (wrActive) begin
      regs[RW] <= BusW;
    end
  end

  // Bypass gives same-cycle WB->ID forwarding; suppressed while in reset.
  always_comb begin
    BusA = '0;
    BusB = '0;
    if (!Rst) begin
      if (RA != 5'd0) begin
        BusA = (wrActive && (RA == RW)) ? BusW : regs[RA];
      end
      if (RB != 5'd0) begin
        BusB = (wrActive && (RB == RW)) ? BusW : regs[RB];
      end
    end
  end

  assign regOut0  = '0;
  assign regOut1  = regs[1];
  assign regOut2  = regs[2];
  assign regOut3  = regs[3];
  assign regOut4  = regs[4];
  assign regOut5  = regs[5];
  assign regOut6  = regs[6];
  assign regOut7  = regs[7];
  assign regOut8  = regs[8];
  assign regOut9  = regs[9];
  assign regOut10 = regs[10];
  assign regOut11 = regs[11];
  assign regOut12 = regs[12];
  assign regOut13 = regs[13];
  assign regOut14 = regs[14];
  assign regOut15 = regs[15];
  assign regOut16 = regs[16];
  assign regOut17 = regs[17];
  assign regOut18 = regs[18];
  assign regOut19 = regs[19];
  assign regOut20 = regs[20];
  assign regOut21 = regs[21];
  assign regOut22 = regs[22];
  assign regOut23 = regs[23];
  assign regOut24 = regs[24];
  assign regOut25 = regs[25];
  assign regOut26 = regs[26];
  assign regOut27 = regs[27];
  assign regOut28 = regs[28];
  assign regOut29 = regs[29];
  assign regOut30 = regs[30];
  assign regOut31 = regs[31];

endmodule

// File: tb/tb_register_file.sv
// Directed and randomized checks of register_file against an array-based reference model.
module tb_register_file;
  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [31:0] BusW = '0;
  logic [4:0]  RW = '0, RA = '0, RB = '0;
  logic        RegWr = 1'b0;
  wire  [31:0] BusA, BusB;
  wire  [31:0] ro [32];

  int          total = 0;
  int          bad = 0;
  logic [31:0] model [32];

  register_file #(.WIDTH(32)) dut (
    .Clk(Clk), .Rst(Rst), .BusW(BusW), .RW(RW), .RegWr(RegWr), .RA(RA), .RB(RB),
    .BusA(BusA), .BusB(BusB),
    .regOut0(ro[0]),   .regOut1(ro[1]),   .regOut2(ro[2]),   .regOut3(ro[3]),
    .regOut4(ro[4]),   .regOut5(ro[5]),   .regOut6(ro[6]),   .regOut7(ro[7]),
    .regOut8(ro[8]),   .regOut9(ro[9]),   .regOut10(ro[10]), .regOut11(ro[11]),
    .regOut12(ro[12]), .regOut13(ro[13]), .regOut14(ro[14]), .regOut15(ro[15]),
    .regOut16(ro[16]), .regOut17(ro[17]), .regOut18(ro[18]), .regOut19(ro[19]),
    .regOut20(ro[20]), .regOut21(ro[21]), .regOut22(ro[22]), .regOut23(ro[23]),
    .regOut24(ro[24]), .regOut25(ro[25]), .regOut26(ro[26]), .regOut27(ro[27]),
    .regOut28(ro[28]), .regOut29(ro[29]), .regOut30(ro[30]), .regOut31(ro[31])
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected read-port value from the current inputs and stored model state.
  function automatic logic [31:0] expRead(input logic [4:0] addr);
    if (Rst || addr == 5'd0) return 32'h0;
    if (RegWr && RW != 5'd0 && addr == RW) return BusW;
    return model[addr];
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // One rising edge; the model commits the write the DUT should commit.
  task automatic tick();
    @(posedge Clk);
    if (!Rst && RegWr && RW != 5'd0) model[RW] = BusW;
    #1;
  endtask

  task automatic checkRegs(input string tag);
    for (int i = 0; i < 32; i++) check($sformatf("%s_regOut%0d", tag, i), ro[i], model[i]);
  endtask

  initial begin
    clearModel();
    #3;
    checkRegs("reset");
    @(negedge Clk);
    Rst = 1'b0;

    // Reset clear without a clock edge
    RegWr = 1'b1; RW = 5'd5; BusW = 32'hDEADBEEF;
    tick();
    RegWr = 1'b0; RA = 5'd5;
    #1;
    check("preload_BusA", BusA, 32'hDEADBEEF);
    check("preload_regOut5", ro[5], 32'hDEADBEEF);
    #2;
    Rst = 1'b1;
    clearModel();
    #1;
    check("rst_regOut5", ro[5], 32'h0);
    check("rst_BusA", BusA, 32'h0);
    checkRegs("rst");
    RegWr = 1'b1; RW = 5'd3; BusW = 32'h33333333; RA = 5'd3;
    #1;
    check("rst_no_bypass", BusA, 32'h0);
    RegWr = 1'b0;
    @(negedge Clk);
    Rst = 1'b0;

    // Basic write/read
    RegWr = 1'b1; RW = 5'd7; BusW = 32'h12345678;
    tick();
    RegWr = 1'b0; RA = 5'd7; RB = 5'd7;
    #1;
    check("basic_BusA", BusA, 32'h12345678);
    check("basic_BusB", BusB, 32'h12345678);
    check("basic_regOut7", ro[7], 32'h12345678);

    // Register-zero immunity
    RegWr = 1'b1; RW = 5'd0; BusW = 32'hFFFFFFFF; RA = 5'd0;
    #1;
    check("zero_BusA_pre", BusA, 32'h0);
    tick();
    RegWr = 1'b0;
    #1;
    check("zero_BusA", BusA, 32'h0);
    check("zero_regOut0", ro[0], 32'h0);

    // Write-through bypass
    RegWr = 1'b1; RW = 5'd3; BusW = 32'h11111111;
    tick();
    BusW = 32'h22222222; RA = 5'd3; RB = 5'd4;
    #1;
    check("bypass_BusA", BusA, 32'h22222222);
    check("bypass_BusB", BusB, 32'h0);
    check("bypass_regOut3_pre", ro[3], 32'h11111111);
    tick();
    RegWr = 1'b0;
    #1;
    check("bypass_regOut3_post", ro[3], 32'h22222222);

    // Write-enable gating
    RegWr = 1'b0; RW = 5'd9; BusW = 32'hAAAA5555;
    tick();
    check("gate_regOut9", ro[9], 32'h0);

    // Full sweep
    for (int i = 1; i < 32; i++) begin
      RegWr = 1'b1; RW = 5'(i); BusW = 32'(i) * 32'h01010101;
      tick();
    end
    RegWr = 1'b0;
    for (int i = 0; i < 32; i++) begin
      RA = 5'(i); RB = 5'(31 - i);
      #1;
      check($sformatf("sweep_BusA%0d", i), BusA, 32'(i) * 32'h01010101);
      check($sformatf("sweep_BusB%0d", 31 - i), BusB, 32'(31 - i) * 32'h01010101);
      check($sformatf("sweep_regOut%0d", i), ro[i], 32'(i) * 32'h01010101);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      RegWr = 1'($urandom_range(0, 1));
      RW = 5'($urandom);
      BusW = $urandom;
      RA = ($urandom_range(0, 3) == 0) ? RW : 5'($urandom);
      RB = ($urandom_range(0, 3) == 0) ? RW : 5'($urandom);
      #1;
      check("rand_BusA", BusA, expRead(RA));
      check("rand_BusB", BusB, expRead(RB));
      tick();
      check("rand_regOutRW", ro[RW], model[RW]);
      if (n == 200) begin
        Rst = 1'b1;
        clearModel();
        #1;
        checkRegs("rand_rst");
        @(negedge Clk);
        Rst = 1'b0;
      end
    end
    RegWr = 1'b0;
    #1;
    checkRegs("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
